filter_line_sequencer: RTL

- Upstream/downstream control stage wrapped around the 3x3 line filter.
- Accepts an RGB565 pixel stream, loads one band of three 240-px rows (cursor 0..719, wren=1) into the filter.
- Then sweeps read cursors 1..238, captures each filtered pixel on the filter's d_rdy, and forwards it on a valid/ready output stream.
- Repeats the load/sweep cycle per band.

---
 rtl/filter_seq_pkg.sv | 34 +++
 rtl/filter_line_sequencer.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/filter_seq_pkg.sv
// ============================================================================
//  Module   : filter_seq_pkg
//  Purpose  : Shared types and constants for the 3x3 line-filter sequencer.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package filter_seq_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    SETTLE = 3'd2,
    READ   = 3'd3,
    EMIT   = 3'd4
  } seq_state_e;

  localparam int unsigned c_ROW_PX    = 240;
  localparam int unsigned c_ROWS      = 3;
  localparam int unsigned c_BAND_PX   = c_ROWS * c_ROW_PX;
  localparam int unsigned c_READ_HOLD = 3;
  localparam int unsigned c_CURSOR_W  = 10;

  // RGB565 field positions
  localparam int unsigned c_RGB_R_MSB = 15;
  localparam int unsigned c_RGB_R_LSB = 11;
  localparam int unsigned c_RGB_G_MSB = 10;
  localparam int unsigned c_RGB_G_LSB = 5;
  localparam int unsigned c_RGB_B_MSB = 4;
  localparam int unsigned c_RGB_B_LSB = 0;

endpackage

`default_nettype wire

// File: rtl/filter_line_sequencer.sv
// ============================================================================
//  Module   : filter_line_sequencer
//  Purpose  : Loads one 3-row band into the line filter, then sweeps the
//             interior cursors and streams the filtered pixels out.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module filter_line_sequencer
  import filter_seq_pkg::*;
#(
  parameter int unsigned ROW_PX    = c_ROW_PX,
  parameter int unsigned ROWS      = c_ROWS,
  parameter int unsigned READ_HOLD = c_READ_HOLD,
  parameter int unsigned CURSOR_W  = c_CURSOR_W
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [15:0]         s_data,
  input  logic                s_valid,
  output logic                s_ready,
  output logic [15:0]         m_data,
  output logic                m_valid,
  input  logic                m_ready,
  output logic                m_last,
  output logic [15:0]         f_d_in,
  output logic                f_wren,
  output logic [CURSOR_W-1:0] f_cursor,
  input  logic [15:0]         f_d_out,
  input  logic                f_d_rdy,
  output logic [15:0]         band_cnt
);

  localparam logic [CURSOR_W-1:0] LAST_LOAD = CURSOR_W'(ROWS * ROW_PX - 1);
  localparam logic [CURSOR_W-1:0] LAST_RD   = CURSOR_W'(ROW_PX - 2);
  localparam logic [CURSOR_W-1:0] FIRST_RD  = CURSOR_W'(1);
  localparam logic [1:0]          HOLD_MIN  = 2'(READ_HOLD);

  seq_state_e          state_q,    state_d;
  logic [CURSOR_W-1:0] load_cnt_q, load_cnt_d;
  logic [CURSOR_W-1:0] rd_cnt_q,   rd_cnt_d;
  logic [1:0]          hold_q,     hold_d;
  logic                s_ready_q,  s_ready_d;
  logic [15:0]         m_data_q,   m_data_d;
  logic                m_valid_q,  m_valid_d;
  logic                m_last_q,   m_last_d;
  logic [15:0]         f_d_in_q,   f_d_in_d;
  logic                f_wren_q,   f_wren_d;
  logic [CURSOR_W-1:0] f_cursor_q, f_cursor_d;
  logic [15:0]         band_cnt_q, band_cnt_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      load_cnt_q <= '0;
      rd_cnt_q   <= '0;
      hold_q     <= '0;
      s_ready_q  <= 1'b0;
      m_data_q   <= '0;
      m_valid_q  <= 1'b0;
      m_last_q   <= 1'b0;
      f_d_in_q   <= '0;
      f_wren_q   <= 1'b0;
      f_cursor_q <= '0;
      band_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      load_cnt_q <= load_cnt_d;
      rd_cnt_q   <= rd_cnt_d;
      hold_q     <= hold_d;
      s_ready_q  <= s_ready_d;
      m_data_q   <= m_data_d;
      m_valid_q  <= m_valid_d;
      m_last_q   <= m_last_d;
      f_d_in_q   <= f_d_in_d;
      f_wren_q   <= f_wren_d;
      f_cursor_q <= f_cursor_d;
      band_cnt_q <= band_cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    load_cnt_d = load_cnt_q;
    rd_cnt_d   = rd_cnt_q;
    hold_d     = hold_q;
    m_data_d   = m_data_q;
    m_valid_d  = m_valid_q;
    m_last_d   = m_last_q;
    f_d_in_d   = f_d_in_q;
    f_wren_d   = 1'b0;
    f_cursor_d = f_cursor_q;
    band_cnt_d = band_cnt_q;

    case (state_q)
      IDLE: begin
        load_cnt_d = '0;
        state_d    = LOAD;
      end
      LOAD: begin
        if (s_valid && s_ready_q) begin
          f_d_in_d   = s_data;
          f_wren_d   = 1'b1;
          f_cursor_d = load_cnt_q;
          load_cnt_d = load_cnt_q + 1'b1;
          if (load_cnt_q == LAST_LOAD) begin
            state_d = SETTLE;
          end
        end
      end
      SETTLE: begin
        rd_cnt_d   = FIRST_RD;
        f_cursor_d = FIRST_RD;
        hold_d     = '0;
        state_d    = READ;
      end
      READ: begin
        f_cursor_d = rd_cnt_q;
        hold_d     = (hold_q == 2'b11) ? hold_q : hold_q + 1'b1;
        // Until the cursor has been stable long enough, a d_rdy may stem
        // from a stale pipeline address that happens to match.
        if ((hold_q >= HOLD_MIN) && f_d_rdy) begin
          m_data_d  = f_d_out;
          m_valid_d = 1'b1;
          m_last_d  = (rd_cnt_q == LAST_RD);
          state_d   = EMIT;
        end
      end
      EMIT: begin
        if (m_valid_q && m_ready) begin
          m_valid_d = 1'b0;
          m_last_d  = 1'b0;
          if (rd_cnt_q == LAST_RD) begin
            band_cnt_d = band_cnt_q + 16'd1;
            load_cnt_d = '0;
            state_d    = LOAD;
          end else begin
            rd_cnt_d   = rd_cnt_q + 1'b1;
            f_cursor_d = rd_cnt_q + 1'b1;
            hold_d     = '0;
            state_d    = READ;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    s_ready_d = (state_d == LOAD);
  end

  assign s_ready  = s_ready_q;
  assign m_data   = m_data_q;
  assign m_valid  = m_valid_q;
  assign m_last   = m_last_q;
  assign f_d_in   = f_d_in_q;
  assign f_wren   = f_wren_q;
  assign f_cursor = f_cursor_q;
  assign band_cnt = band_cnt_q;

endmodule

`default_nettype wire
